// File: rtl/lisp_cell_heap_if.sv
// Request/response channel between the Lisp datapath and the cons-cell heap.
// The master issues CONS/READ/FREE requests; the slave (heap) returns one response per request.
interface lisp_cell_heap_if #(
    parameter int TAG_W  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [TAG_W-1:0]  req_car_tag;
    logic [DATA_W-1:0] req_car_val;
    logic [ADDR_W-1:0] req_cdr;
    logic [ADDR_W-1:0] req_ptr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_ptr;
    logic [TAG_W-1:0]  rsp_car_tag;
    logic [DATA_W-1:0] rsp_car_val;
    logic [ADDR_W-1:0] rsp_cdr;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_car_tag, req_car_val, req_cdr, req_ptr, rsp_ready,
        input  req_ready, rsp_valid, rsp_ptr, rsp_car_tag, rsp_car_val, rsp_cdr, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_car_tag, req_car_val, req_cdr, req_ptr, rsp_ready,
        output req_ready, rsp_valid, rsp_ptr, rsp_car_tag, rsp_car_val, rsp_cdr, rsp_err
    );
endinterface

// File: rtl/lisp_cell_heap.sv
// Cons-cell heap: single-port synchronous cell store with a LIFO free list backed by a bump allocator.
// Slot 0 is NIL and is never handed out.
module lisp_cell_heap #(
    parameter int  TAG_W  = 16,
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    lisp_cell_heap_if.slave   bus,
    output logic [ADDR_W:0]   free_count
);
    localparam int CELL_W = TAG_W + DATA_W + ADDR_W;
    localparam logic [ADDR_W:0] MAX_FREE = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [1:0] OP_CONS = 2'd0;
    localparam logic [1:0] OP_READ = 2'd1;
    localparam logic [1:0] OP_FREE = 2'd2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t state, state_nx;
    logic [CELL_W-1:0] mem [DEPTH];
    logic [CELL_W-1:0] rd_q;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [CELL_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] rsp_ptr_q, rsp_ptr_nx, rsp_cdr_q, rsp_cdr_nx;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_nx;
    logic [DATA_W-1:0] rsp_val_q, rsp_val_nx;
    logic              rsp_err_q, rsp_err_nx;
    logic [ADDR_W-1:0] head_q, head_nx, ptr_q, ptr_nx;
    logic [ADDR_W:0]   bump_q, bump_nx, fc_q, fc_nx;
    logic              is_cons_q, is_cons_nx;
    logic [CELL_W-1:0] cell_q, cell_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_ptr_q <= '0;
            rsp_cdr_q <= '0;
            rsp_tag_q <= '0;
            rsp_val_q <= '0;
            rsp_err_q <= 1'b0;
            head_q    <= '0;
            ptr_q     <= '0;
            bump_q    <= ONE;
            fc_q      <= MAX_FREE;
            is_cons_q <= 1'b0;
            cell_q    <= '0;
        end else begin
            state     <= state_nx;
            rsp_ptr_q <= rsp_ptr_nx;
            rsp_cdr_q <= rsp_cdr_nx;
            rsp_tag_q <= rsp_tag_nx;
            rsp_val_q <= rsp_val_nx;
            rsp_err_q <= rsp_err_nx;
            head_q    <= head_nx;
            ptr_q     <= ptr_nx;
            bump_q    <= bump_nx;
            fc_q      <= fc_nx;
            is_cons_q <= is_cons_nx;
            cell_q    <= cell_nx;
        end
    end

    // Cell layout is {tag, val, cdr}; the store itself is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_addr];
    end

    always_comb begin
        state_nx   = state;
        rsp_ptr_nx = rsp_ptr_q;
        rsp_cdr_nx = rsp_cdr_q;
        rsp_tag_nx = rsp_tag_q;
        rsp_val_nx = rsp_val_q;
        rsp_err_nx = rsp_err_q;
        head_nx    = head_q;
        ptr_nx     = ptr_q;
        bump_nx    = bump_q;
        fc_nx      = fc_q;
        is_cons_nx = is_cons_q;
        cell_nx    = cell_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nx   = RESP;
                    rsp_ptr_nx = '0;
                    rsp_cdr_nx = '0;
                    rsp_tag_nx = '0;
                    rsp_val_nx = '0;
                    rsp_err_nx = 1'b0;
                    is_cons_nx = (bus.req_op == OP_CONS);
                    cell_nx    = {bus.req_car_tag, bus.req_car_val, bus.req_cdr};
                    ptr_nx     = (bus.req_op == OP_CONS) ? head_q : bus.req_ptr;
                    case (bus.req_op)
                        OP_CONS: begin
                            if (head_q != '0) begin
                                mem_re   = 1'b1;
                                mem_addr = head_q;
                                state_nx = RD_WAIT;
                            end else if (bump_q <= MAX_FREE) begin
                                mem_we     = 1'b1;
                                mem_addr   = bump_q[ADDR_W-1:0];
                                mem_wdata  = {bus.req_car_tag, bus.req_car_val, bus.req_cdr};
                                rsp_ptr_nx = bump_q[ADDR_W-1:0];
                                bump_nx    = bump_q + ONE;
                                fc_nx      = fc_q - ONE;
                            end else begin
                                rsp_err_nx = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (bus.req_ptr == '0) begin
                                rsp_err_nx = 1'b1;
                            end else begin
                                mem_re   = 1'b1;
                                mem_addr = bus.req_ptr;
                                state_nx = RD_WAIT;
                            end
                        end
                        OP_FREE: begin
                            if (bus.req_ptr == '0) begin
                                rsp_err_nx = 1'b1;
                            end else begin
                                mem_we     = 1'b1;
                                mem_addr   = bus.req_ptr;
                                mem_wdata  = {{TAG_W{1'b0}}, {DATA_W{1'b0}}, head_q};
                                head_nx    = bus.req_ptr;
                                rsp_ptr_nx = bus.req_ptr;
                                fc_nx      = (fc_q == MAX_FREE) ? fc_q : fc_q + ONE;
                            end
                        end
                        default: rsp_err_nx = 1'b1;
                    endcase
                end
            end
            RD_WAIT: begin
                state_nx   = RESP;
                rsp_ptr_nx = ptr_q;
                // A CONS here is popping the free list: old head's cdr becomes the new head.
                if (is_cons_q) begin
                    head_nx   = rd_q[ADDR_W-1:0];
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = cell_q;
                    fc_nx     = fc_q - ONE;
                end else begin
                    {rsp_tag_nx, rsp_val_nx, rsp_cdr_nx} = rd_q;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_ptr     = rsp_ptr_q;
    assign bus.rsp_car_tag = rsp_tag_q;
    assign bus.rsp_car_val = rsp_val_q;
    assign bus.rsp_cdr     = rsp_cdr_q;
    assign bus.rsp_err     = rsp_err_q;
    assign free_count      = fc_q;
endmodule

// File: tb/tb_lisp_cell_heap.sv
// Scoreboard bench for lisp_cell_heap on a 4-slot heap: directed requests push expected
// responses; a monitor pops and compares on each new response.
module tb_lisp_cell_heap;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [AW-1:0] ptr;
        logic [15:0]   tag;
        logic [15:0]   val;
        logic [AW-1:0] cdr;
        logic          err;
        int            lat;
        logic [AW:0]   fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [AW:0] free_count;
    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic        prev_valid = 1'b0;

    lisp_cell_heap_if #(.TAG_W(16), .DATA_W(16), .ADDR_W(AW)) bus ();

    lisp_cell_heap #(.TAG_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .free_count (free_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.req_valid && bus.req_ready) acc_cyc = cyc;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rst_n && bus.rsp_valid && !prev_valid) begin
            n_tests++;
            lat = cyc - acc_cyc;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected actual ptr=%0d err=%0b required no response",
                         bus.rsp_ptr, bus.rsp_err);
            end else begin
                e = sbq.pop_front();
                if (bus.rsp_ptr !== e.ptr || bus.rsp_car_tag !== e.tag || bus.rsp_car_val !== e.val ||
                    bus.rsp_cdr !== e.cdr || bus.rsp_err !== e.err || lat != e.lat ||
                    free_count !== e.fc) begin
                    n_fail++;
                    $display("FAIL rsp actual ptr=%0d tag=%0h val=%0h cdr=%0d err=%0b lat=%0d fc=%0d required ptr=%0d tag=%0h val=%0h cdr=%0d err=%0b lat=%0d fc=%0d",
                             bus.rsp_ptr, bus.rsp_car_tag, bus.rsp_car_val, bus.rsp_cdr, bus.rsp_err, lat, free_count,
                             e.ptr, e.tag, e.val, e.cdr, e.err, e.lat, e.fc);
                end
            end
        end
        prev_valid = rst_n && bus.rsp_valid;
    end

    function automatic exp_t mk(input logic [AW-1:0] ptr, input logic [15:0] tag, val,
                                input logic [AW-1:0] cdr, input logic err, input int lat,
                                input logic [AW:0] fc);
        exp_t e;
        e.ptr = ptr; e.tag = tag; e.val = val; e.cdr = cdr; e.err = err; e.lat = lat; e.fc = fc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] tag, val,
                        input logic [AW-1:0] cdr, ptr, input exp_t e, input bit expect_rsp);
        int n = 0;
        if (expect_rsp) sbq.push_back(e);
        @(negedge clk);
        bus.req_op = op; bus.req_car_tag = tag; bus.req_car_val = val;
        bus.req_cdr = cdr; bus.req_ptr = ptr; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic cons(input logic [15:0] tag, val, input logic [AW-1:0] cdr,
                        input logic [AW-1:0] eptr, input logic eerr, input int lat, input logic [AW:0] fc);
        send(2'd0, tag, val, cdr, '0, mk(eptr, 16'h0, 16'h0, '0, eerr, lat, fc), 1'b1);
    endtask

    task automatic rd(input logic [AW-1:0] ptr, input logic [15:0] etag, eval,
                      input logic [AW-1:0] ecdr, input logic [AW:0] fc);
        if (ptr == '0) send(2'd1, '0, '0, '0, ptr, mk('0, 16'h0, 16'h0, '0, 1'b1, 1, fc), 1'b1);
        else           send(2'd1, '0, '0, '0, ptr, mk(ptr, etag, eval, ecdr, 1'b0, 2, fc), 1'b1);
    endtask

    task automatic fr(input logic [AW-1:0] ptr, input logic [AW:0] fc);
        send(2'd2, '0, '0, '0, ptr, mk(ptr, 16'h0, 16'h0, '0, (ptr == '0), 1, fc), 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !bus.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_car_tag = '0; bus.req_car_val = '0;
        bus.req_cdr = '0; bus.req_ptr = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_ptr",   32'(bus.rsp_ptr), 32'd0);
        chk("reset_rsp_val",   32'(bus.rsp_car_val), 32'd0);
        chk("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("reset_free_count", 32'(free_count), 32'd3);

        // Bump allocation and read-back.
        cons(16'h0, 16'h002A, 2'd0, 2'd1, 1'b0, 1, 3'd2);
        rd(2'd1, 16'h0, 16'h002A, 2'd0, 3'd2);
        // LIFO free list, then bump, then exhaustion.
        cons(16'h1, 16'h0011, 2'd1, 2'd2, 1'b0, 1, 3'd1);
        fr(2'd1, 3'd2);
        fr(2'd2, 3'd3);
        cons(16'h2, 16'h0022, 2'd0, 2'd2, 1'b0, 2, 3'd2);
        cons(16'h2, 16'h0033, 2'd2, 2'd1, 1'b0, 2, 3'd1);
        cons(16'h0, 16'h0044, 2'd0, 2'd3, 1'b0, 1, 3'd0);
        cons(16'h1, 16'h0066, 2'd0, 2'd0, 1'b1, 1, 3'd0);
        fr(2'd2, 3'd1);
        cons(16'h1, 16'h0055, 2'd3, 2'd2, 1'b0, 2, 3'd0);
        rd(2'd2, 16'h1, 16'h0055, 2'd3, 3'd0);
        rd(2'd1, 16'h2, 16'h0033, 2'd2, 3'd0);
        fr(2'd3, 3'd1);
        rd(2'd3, 16'h0, 16'h0000, 2'd0, 3'd1);
        // NIL and reserved-op errors.
        rd(2'd0, 16'h0, 16'h0, 2'd0, 3'd1);
        fr(2'd0, 3'd1);
        send(2'd3, 16'h7, 16'h7, 2'd1, 2'd0, mk('0, 16'h0, 16'h0, '0, 1'b1, 1, 3'd1), 1'b1);
        drain();

        // Response back-pressure.
        bus.rsp_ready = 1'b0;
        rd(2'd2, 16'h1, 16'h0055, 2'd3, 3'd1);
        begin
            int n = 0;
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_val",   32'(bus.rsp_car_val), 32'h55);
            chk("stall_rsp_cdr",   32'(bus.rsp_cdr), 32'd3);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Reset while a READ is in RD_WAIT.
        send(2'd1, '0, '0, '0, 2'd2, mk('0, '0, '0, '0, 1'b0, 0, '0), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midreset_free_count", 32'(free_count), 32'd3);
        @(negedge clk) rst_n = 1'b1;
        cons(16'h1, 16'h0077, 2'd0, 2'd1, 1'b0, 1, 3'd2);
        fr(2'd1, 3'd3);
        fr(2'd1, 3'd3);
        drain();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
